multiplicador4b_seq: RTL and testbench

Sequential 4x4 unsigned shift-and-add multiplier built around the existing 4-bit ripple adder `somador4b`. It accepts one operand pair on a start strobe and runs four add/shift iterations. It then presents an 8-bit product with a one-cycle done pulse. It sits directly downstream of `somador4b`, consuming its sum/carry every cycle, and upstream of it, supplying its operands from internal registers.

---
 rtl/mult_pkg.sv | 17 +
 rtl/multiplicador4b_seq_if.sv | 21 ++
 rtl/somador4b.sv | 22 ++
 rtl/multiplicador4b_seq.sv | 92 +++++++++
 tb/tb_multiplicador4b_seq.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
package mult_pkg;

    // Number of add/shift iterations, one per multiplier bit.
    localparam int N_ITER = 4;

    // Counter value on which the last iteration is performed.
    localparam logic [1:0] LAST_CNT = 2'(N_ITER - 1);

    // FSM state encoding.
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } estado_t;

endpackage

// File: rtl/multiplicador4b_seq_if.sv
// Operand/result bundle of the multiplier; the master issues operands, the slave computes.
interface multiplicador4b_seq_if;

    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       busy;
    logic       done;

    modport master (
        output start, a, b,
        input  p, busy, done
    );

    modport slave (
        input  start, a, b,
        output p, busy, done
    );

endinterface

// File: rtl/somador4b.sv
// 4-bit ripple-carry adder, purely combinational.
module somador4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    // One full adder per bit, carry rippling upward.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[4];

endmodule

// File: rtl/multiplicador4b_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier around somador4b.
// {acc, rb} forms the 8-bit product register; rb starts as the multiplier
// and is shifted out one bit per iteration as product bits shift in.
module multiplicador4b_seq
    import mult_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    multiplicador4b_seq_if.slave       bus
);

    estado_t    estado_q;
    logic [3:0] ra_q;
    logic [3:0] acc_q;
    logic [3:0] rb_q;
    logic [1:0] cnt_q;
    logic       busy_q;
    logic       done_q;

    logic [3:0] addend;
    logic [3:0] sum;
    logic       cout;
    logic [3:0] acc_d;
    logic [3:0] rb_d;

    // Partial product for this iteration: multiplicand if the current multiplier bit is set.
    assign addend = rb_q[0] ? ra_q : 4'b0000;

    somador4b u_somador (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // 9-bit right shift of {cout, sum, rb}; the carry lands in acc[3], old rb[0] drops out.
    assign {acc_d, rb_d} = {cout, sum, rb_q[3:1]};

    // FSM plus datapath registers; busy/done are registered alongside the state.
    // NOTE: asynchronous active-low reset clears every register, and all state updates use <= so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            ra_q     <= '0;
            acc_q    <= '0;
            rb_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO, FIM: begin
                    if (bus.start) begin
                        estado_q <= CALC;
                        ra_q     <= bus.a;
                        rb_q     <= bus.b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end else begin
                        estado_q <= OCIOSO;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    rb_q  <= rb_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == LAST_CNT) begin
                        estado_q <= FIM;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p    = {acc_q, rb_q};
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_multiplicador4b_seq.sv
// Self-checking bench for multiplicador4b_seq: directed table, protocol corner cases,
// random operands and an exhaustive sweep, all checked against plain a*b.
module tb_multiplicador4b_seq;

    logic clk;
    logic rst_n;

    multiplicador4b_seq_if bus ();

    multiplicador4b_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Present operands with start for one edge (E0); returns #1 after E0 with start low.
    task automatic start_op(input logic [3:0] a_v, input logic [3:0] b_v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a_v;
        bus.b     = b_v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count cycles from E0 until done, bounded; also counts cycles with busy high.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = 0;
        busy_cycles = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full operation: latency, busy width, product, and single-cycle done pulse.
    task automatic run_op(input string name, input logic [3:0] a_v, input logic [3:0] b_v,
                          input logic [7:0] exp_p);
        int lat;
        int bc;
        start_op(a_v, b_v);
        wait_done(lat, bc);
        check({name, " latency"}, lat, 4);
        check({name, " busy_cycles"}, bc, 4);
        check({name, " p"}, bus.p, exp_p);
        @(posedge clk);
        #1;
        check({name, " done_width"}, bus.done, 0);
        check({name, " p_hold"}, bus.p, exp_p);
    endtask

    initial begin
        int lat;
        int bc;
        logic [3:0] ra;
        logic [3:0] rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;

        // Directed vectors from the test plan, expectations written as constants.
        vecs.push_back('{a: 4'd3,  b: 4'd6,  p: 8'h12});
        vecs.push_back('{a: 4'd15, b: 4'd15, p: 8'hE1});
        vecs.push_back('{a: 4'd0,  b: 4'd9,  p: 8'h00});
        vecs.push_back('{a: 4'd9,  b: 4'd0,  p: 8'h00});
        vecs.push_back('{a: 4'd1,  b: 4'd1,  p: 8'h01});
        vecs.push_back('{a: 4'd8,  b: 4'd8,  p: 8'h40});

        // Reset state
        #12;
        check("reset p", bus.p, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Mid-CALC start ignored, then start held through FIM is accepted at E5.
        start_op(4'd5, 4'd7);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd1;
        lat = 1;
        bc  = 1;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("midstart latency", lat, 4);
        check("midstart busy_cycles", bc, 4);
        check("midstart p", bus.p, 35);
        bus.a = 4'd2;
        bus.b = 4'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b accepted busy", bus.busy, 1);
        check("b2b accepted done", bus.done, 0);
        wait_done(lat, bc);
        check("b2b latency", lat, 4);
        check("b2b p", bus.p, 14);
        @(posedge clk);
        #1;
        check("b2b done_width", bus.done, 0);

        // Reset in the second CALC cycle aborts immediately.
        start_op(4'd3, 4'd6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort p", bus.p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_abort", 4'd12, 4'd4, 8'h30);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            run_op($sformatf("rand%0d_%0dx%0d", i, ra, rb), ra, rb, 8'(ra * rb));
        end

        // Exhaustive sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op($sformatf("sweep_%0dx%0d", x, y), 4'(x), 4'(y), 8'(x * y));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
